// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues requests to a 1-cycle synchronous IMEM,
// and buffers returned words in a small FIFO that feeds decode over valid/ready.
module riscv_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  fifo_pc_q    [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_instr_q [FIFO_DEPTH];

    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             push;
    logic             pop;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A slot is reserved at issue time; a same-cycle pop is deliberately not credited,
    // which keeps out_ready off the imem_req path.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign issue     = !reset && !redirect_valid && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign push      = inflight_q && !redirect_valid && !reset;
    assign pop       = out_valid && out_ready;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;
    assign out_valid = !reset && (count_q != '0);
    assign out_pc    = reset ? '0 : fifo_pc_q[rd_ptr_q];
    assign out_instr = reset ? '0 : fifo_instr_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (issue) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            inflight_pc_d = fetch_pc_q;
        end
        if (redirect_valid) begin
            // Flush everything; the pending response (if any) is dropped via push=0.
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Datapath storage carries no reset; validity is tracked by count_q/inflight_q.
    always_ff @(posedge clk) begin
        inflight_pc_q <= inflight_pc_d;
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
